sdram_read_arbiter: RTL



---
 rtl/sdram_read_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sdram_read_arbiter.sv
// Two-master Avalon-MM read arbiter for a shared 64-bit SDRAM read port, with in-order return routing.
// Define SDRAM_READ_ARBITER_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority m1 > m0).
module sdram_read_arbiter #(
    parameter int unsigned ORDER_DEPTH      = 16,
    parameter int unsigned ORDER_DEPTH_LOG2 = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [28:0] m0_address,
    input  logic [7:0]  m0_burstcount,
    input  logic        m0_read,
    output logic        m0_waitrequest,
    output logic [63:0] m0_readdata,
    output logic        m0_readdatavalid,
    input  logic [28:0] m1_address,
    input  logic [7:0]  m1_burstcount,
    input  logic        m1_read,
    output logic        m1_waitrequest,
    output logic [63:0] m1_readdata,
    output logic        m1_readdatavalid,
    output logic [28:0] slave_address,
    output logic [7:0]  slave_burstcount,
    output logic        slave_read,
    input  logic        slave_waitrequest,
    input  logic [63:0] slave_readdata,
    input  logic        slave_readdatavalid,
    output logic        protocol_error
);
    localparam int unsigned BW = 8;
    localparam int unsigned CW = ORDER_DEPTH_LOG2 + 1;
    localparam int unsigned PW = ORDER_DEPTH_LOG2;

    typedef struct packed {
        logic          id;
        logic [BW-1:0] burst;
    } tag_t;

    logic          grant;
    logic          grant_nxt;
    logic          locked;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [BW-1:0] beat_cnt;
    tag_t          tags [ORDER_DEPTH];
    tag_t          head;
    logic [BW-1:0] last_idx;
    logic          full;
    logic          empty;
    logic          accept;
    logic          stall;
    logic          ret_ok;
    logic          pop;
`ifdef SDRAM_READ_ARBITER_ROUND_ROBIN_EN
    logic          rr_pri;
`endif

    // Request forwarding, handshakes and return routing
    always_comb begin
        full             = (count == CW'(ORDER_DEPTH));
        empty            = (count == '0);
        head             = tags[rd_ptr];
        slave_address    = grant ? m1_address    : m0_address;
        slave_burstcount = grant ? m1_burstcount : m0_burstcount;
        slave_read       = !reset && (grant ? m1_read : m0_read) && !full;
        accept           = slave_read && !slave_waitrequest;
        stall            = slave_read && slave_waitrequest;
        m0_waitrequest   = reset || grant  || slave_waitrequest || full;
        m1_waitrequest   = reset || !grant || slave_waitrequest || full;
        ret_ok           = !reset && slave_readdatavalid && !empty;
        // A zero burstcount is treated as a single beat
        last_idx         = (head.burst == '0) ? '0 : head.burst - BW'(1);
        pop              = ret_ok && (beat_cnt == last_idx);
        m0_readdata      = slave_readdata;
        m1_readdata      = slave_readdata;
        m0_readdatavalid = ret_ok && !head.id;
        m1_readdatavalid = ret_ok && head.id;
    end

    // Arbitration choice for the next grant
    always_comb begin
        grant_nxt = grant;
`ifdef SDRAM_READ_ARBITER_ROUND_ROBIN_EN
        if (m0_read && m1_read) grant_nxt = rr_pri;
        else if (m1_read)       grant_nxt = 1'b1;
        else if (m0_read)       grant_nxt = 1'b0;
`else
        if (m1_read)            grant_nxt = 1'b1;
        else if (m0_read)       grant_nxt = 1'b0;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant          <= 1'b0;
            locked         <= 1'b0;
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            beat_cnt       <= '0;
            protocol_error <= 1'b0;
`ifdef SDRAM_READ_ARBITER_ROUND_ROBIN_EN
            rr_pri         <= 1'b1;
`endif
        end else begin
            if (!locked && !accept) grant <= grant_nxt;

            if (accept)     locked <= 1'b0;
            else if (stall) locked <= 1'b1;

            if (accept) wr_ptr <= wr_ptr + PW'(1);

            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                beat_cnt <= '0;
            end else if (ret_ok) begin
                beat_cnt <= beat_cnt + BW'(1);
            end

            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (slave_readdatavalid && empty) protocol_error <= 1'b1;
`ifdef SDRAM_READ_ARBITER_ROUND_ROBIN_EN
            if (accept) rr_pri <= ~grant;
`endif
        end
    end

    // Tag storage; accept is already gated off while in reset
    always_ff @(posedge clock) begin
        if (accept) tags[wr_ptr] <= '{id: grant, burst: slave_burstcount};
    end

endmodule
